// File: rtl/mac_tx_gmii_if.sv
// -----------------------------------------------------------------------------
// mac_tx_gmii_if -- upstream frame handshake between a frame source and the
// GMII transmit MAC.
//
//   mac_tx_rq     source -> MAC  frame request, held until granted
//   mac_tx_ack    MAC -> source  one-cycle grant; first byte follows next cycle
//   mac_tx_data   source -> MAC  payload byte
//   mac_tx_valid  source -> MAC  mac_tx_data valid
//   mac_tx_sof    source -> MAC  first byte marker (informational)
//   mac_tx_eof    source -> MAC  last byte marker
//
// master = frame source, slave = MAC.
// -----------------------------------------------------------------------------
interface mac_tx_gmii_if;
  logic       mac_tx_rq;
  logic       mac_tx_ack;
  logic [7:0] mac_tx_data;
  logic       mac_tx_valid;
  logic       mac_tx_sof;
  logic       mac_tx_eof;

  modport master (
    output mac_tx_rq,
    output mac_tx_data,
    output mac_tx_valid,
    output mac_tx_sof,
    output mac_tx_eof,
    input  mac_tx_ack
  );

  modport slave (
    input  mac_tx_rq,
    input  mac_tx_data,
    input  mac_tx_valid,
    input  mac_tx_sof,
    input  mac_tx_eof,
    output mac_tx_ack
  );
endinterface

// File: rtl/mac_tx_gmii.sv
// -----------------------------------------------------------------------------
// mac_tx_gmii -- Ethernet transmit MAC producing a GMII byte stream.
//
// Frames a payload from the upstream handshake as:
//   7 x 0x55 preamble, 0xD5 SFD, payload, zero pad up to MIN_LEN bytes,
//   4-byte IEEE 802.3 CRC-32 FCS, then IFG_CYCLES idle cycles.
// A missing byte mid-payload aborts the frame with one tx_er cycle.
//
// Ports
//   clk          single clock
//   rst          synchronous, active-high reset
//   mac_tx       upstream handshake (slave side of mac_tx_gmii_if)
//   gmii_txd     GMII transmit data
//   gmii_tx_en   GMII transmit enable
//   gmii_tx_er   GMII transmit error (only on underrun)
//   tx_busy      high whenever the FSM is not IDLE
//   tx_done      one-cycle pulse in the first idle cycle after a good frame
//   tx_underrun  one-cycle pulse coincident with the tx_er cycle
//
// Timing model: every output is a register. The FSM state in cycle t decides
// what the wire shows in cycle t+1, so the DATA state starts in the SFD
// cycle -- exactly when upstream presents its first byte.
// -----------------------------------------------------------------------------
module mac_tx_gmii #(
  parameter int IFG_CYCLES = 12,
  parameter int MIN_LEN    = 60
) (
  input  logic         clk,
  input  logic         rst,
  mac_tx_gmii_if.slave mac_tx,
  output logic [7:0]   gmii_txd,
  output logic         gmii_tx_en,
  output logic         gmii_tx_er,
  output logic         tx_busy,
  output logic         tx_done,
  output logic         tx_underrun
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    PAD,
    FCS,
    IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [15:0] MIN_LEN_W     = 16'(MIN_LEN);
  localparam logic [15:0] IFG_LAST      = 16'(IFG_CYCLES - 1);

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data_in);
    logic [31:0] c;
    c = crc_in ^ {24'd0, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  state_t      state;
  state_t      state_d;
  logic [15:0] step;       // cycles spent in the current state
  logic        rearm;      // a new frame may start only after rq was seen low
  logic [31:0] crc;
  logic [15:0] count;      // payload + pad bytes emitted so far
  logic [15:0] count_inc;
  logic        launch;
  logic        byte_take;  // a payload or pad byte goes out this cycle
  logic [31:0] crc_inv;
  logic        ack_q;

  logic [7:0]  txd_d;
  logic        tx_en_d;
  logic        tx_er_d;
  logic        ack_d;
  logic        done_d;
  logic        underrun_d;

  // sof carries no function: framing relies on the grant and on eof.
  logic unused_sof;
  assign unused_sof = mac_tx.mac_tx_sof;

  assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;
  assign launch    = (state == IDLE) && mac_tx.mac_tx_rq && rearm;
  assign byte_take = ((state == DATA) && mac_tx.mac_tx_valid) || (state == PAD);
  assign crc_inv   = ~crc;

  assign mac_tx.mac_tx_ack = ack_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= 16'd0;
    end else begin
      state <= state_d;
      if ((state_d != state) || (state == IDLE)) begin
        step <= 16'd0;
      end else begin
        step <= step + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first; a path that leaves
  // it unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:     if (launch) state_d = PREAMBLE;
      // step 6 drives the SFD; the first payload byte is sampled next cycle.
      PREAMBLE: if (step == 16'd6) state_d = DATA;
      DATA: begin
        if (!mac_tx.mac_tx_valid) begin
          state_d = IFG;
        end else if (mac_tx.mac_tx_eof) begin
          state_d = (count_inc < MIN_LEN_W) ? PAD : FCS;
        end
      end
      PAD:      if (count_inc >= MIN_LEN_W) state_d = FCS;
      FCS:      if (step == 16'd3) state_d = IFG;
      IFG:      if (step == IFG_LAST) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (values the output registers take at the next edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    txd_d      = 8'h00;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (launch) begin
          txd_d   = PREAMBLE_BYTE;
          tx_en_d = 1'b1;
        end
      end
      PREAMBLE: begin
        // Byte 0 left with the launch, so step k drives byte k+1.
        tx_en_d = 1'b1;
        txd_d   = (step == 16'd6) ? SFD_BYTE : PREAMBLE_BYTE;
        ack_d   = (step == 16'd5);
      end
      DATA: begin
        tx_en_d = 1'b1;
        if (mac_tx.mac_tx_valid) begin
          txd_d = mac_tx.mac_tx_data;
        end else begin
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
        end
      end
      PAD: begin
        tx_en_d = 1'b1;
      end
      FCS: begin
        tx_en_d = 1'b1;
        txd_d   = crc_inv[{step[1:0], 3'b000} +: 8];
      end
      IFG: begin
        // In the first IFG cycle the wire still shows the frame's last cycle:
        // a clean FCS byte means a good frame, a tx_er cycle means an abort.
        done_d = (step == 16'd0) && gmii_tx_en && !gmii_tx_er;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers, CRC, byte count and rearm
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      gmii_txd    <= 8'h00;
      gmii_tx_en  <= 1'b0;
      gmii_tx_er  <= 1'b0;
      ack_q       <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
      rearm       <= 1'b1;
      crc         <= CRC_INIT;
      count       <= 16'd0;
    end else begin
      gmii_txd    <= txd_d;
      gmii_tx_en  <= tx_en_d;
      gmii_tx_er  <= tx_er_d;
      ack_q       <= ack_d;
      tx_busy     <= (state_d != IDLE);
      tx_done     <= done_d;
      tx_underrun <= underrun_d;

      // A request held high across a whole frame must not start another one.
      if (ack_d) begin
        rearm <= 1'b0;
      end else if (!mac_tx.mac_tx_rq) begin
        rearm <= 1'b1;
      end

      if (state == IDLE) begin
        crc   <= CRC_INIT;
        count <= 16'd0;
      end else if (byte_take) begin
        crc   <= crc32_byte(crc, txd_d);
        count <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_mac_tx_gmii.sv
// -----------------------------------------------------------------------------
// tb_mac_tx_gmii -- directed bench for mac_tx_gmii.
//
// An upstream model reacts to the grant, feeds payload bytes, and records the
// GMII stream. Expected bytes come from the stored payload; the FCS is checked
// through the CRC-32 residue of payload+pad+FCS (0x2144DF1C).
// -----------------------------------------------------------------------------
module tb_mac_tx_gmii;

  localparam int IFG  = 12;
  localparam int MINL = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_underrun;

  always #5 clk = ~clk;

  mac_tx_gmii_if bus ();

  mac_tx_gmii #(
    .IFG_CYCLES (IFG),
    .MIN_LEN    (MINL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mac_tx      (bus),
    .gmii_txd    (gmii_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_underrun (tx_underrun)
  );

  int         tests;
  int         fails;
  int         cyc;
  logic [7:0] pl [0:1513];
  logic [7:0] cap [$];

  // Per-frame observations filled by run_frame.
  int   en_cnt, first_en, last_en;
  int   ack_cnt, ack_pos;
  int   done_cnt, done_cyc;
  int   un_cnt, er_cnt, er_pos;
  int   en_after;
  logic busy_end;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  function automatic logic [31:0] zlib_crc_of_cap(input int from);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = from; i < cap.size(); i++) begin
      c = c ^ {24'd0, cap[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // rq_mode: 0 = drop rq after ack, 1 = rq low for one cycle after ack then
  // high again, 2 = rq held high throughout.
  // stop_after >= 0: stop feeding after that many bytes (underrun).
  // rst_at >= 0: assert rst while payload byte rst_at is on the wire.
  task automatic run_frame(input int len, input int stop_after, input int rst_at,
                           input int rq_mode, input int tail);
    int idx;
    int ack_cyc;
    int end_cyc;
    int post_rst;
    bit ended;
    bit finished;
    bit rst_sent;
    idx = 0; ack_cyc = -1; end_cyc = 0; post_rst = -1;
    ended = 0; finished = 0; rst_sent = 0;
    cap.delete();
    en_cnt = 0; first_en = -1; last_en = -1; ack_cnt = 0; ack_pos = -1;
    done_cnt = 0; done_cyc = -1; un_cnt = 0; er_cnt = 0; er_pos = -1;
    en_after = 0; busy_end = 1'b0;
    bus.mac_tx_rq = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      cyc++;
      // ---- observe ----
      if (ended && gmii_tx_en) en_after++;
      if (gmii_tx_en) begin
        cap.push_back(gmii_txd);
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      if (gmii_tx_er) begin
        er_cnt++;
        er_pos = cap.size() - 1;
      end
      if (bus.mac_tx_ack) begin
        ack_cnt++;
        ack_pos = cap.size() - 1;
        if (ack_cyc < 0) ack_cyc = cyc;
      end
      if (tx_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (tx_underrun) un_cnt++;
      if (cyc == post_rst) begin
        check("reset tx_en", 32'(gmii_tx_en), 32'd0);
        check("reset ack", 32'(bus.mac_tx_ack), 32'd0);
        check("reset tx_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        ended = 1;
        end_cyc = cyc + tail;
      end
      if (!ended && (tx_done || tx_underrun)) begin
        ended = 1;
        end_cyc = cyc + tail;
      end
      if (ended && cyc >= end_cyc) begin
        finished = 1;
        busy_end = tx_busy;
        break;
      end
      if (rst_at >= 0 && !rst_sent && gmii_tx_en && cap.size() == 9 + rst_at) begin
        rst = 1'b1;
        rst_sent = 1;
        post_rst = cyc + 1;
      end
      // ---- drive ----
      if (rq_mode == 2) bus.mac_tx_rq = 1'b1;
      else if (rq_mode == 1) bus.mac_tx_rq = (cyc != ack_cyc);
      else bus.mac_tx_rq = (ack_cyc < 0);
      if (ack_cyc >= 0 && cyc > ack_cyc && !rst_sent && idx < len &&
          !(stop_after >= 0 && idx >= stop_after)) begin
        bus.mac_tx_valid = 1'b1;
        bus.mac_tx_data  = pl[idx];
        bus.mac_tx_sof   = (idx == 0);
        bus.mac_tx_eof   = (idx == len - 1);
        idx++;
      end else if (ack_cyc < 0) begin
        // Junk before the grant; the MAC must ignore it.
        bus.mac_tx_valid = 1'b1;
        bus.mac_tx_data  = 8'hEE;
        bus.mac_tx_sof   = 1'b1;
        bus.mac_tx_eof   = 1'b1;
      end else begin
        bus.mac_tx_valid = 1'b0;
        bus.mac_tx_data  = 8'h00;
        bus.mac_tx_sof   = 1'b0;
        bus.mac_tx_eof   = 1'b0;
      end
    end
    check("frame finished within budget", 32'(finished), 32'd1);
    bus.mac_tx_valid = 1'b0;
    bus.mac_tx_data  = 8'h00;
    bus.mac_tx_sof   = 1'b0;
    bus.mac_tx_eof   = 1'b0;
  endtask

  task automatic verify_good(input string tag, input int len, input logic exp_busy);
    int plen;
    int bad;
    logic [7:0] e;
    plen = (len < MINL) ? MINL : len;
    bad = 0;
    check({tag, " tx_en cycles"}, en_cnt, 8 + plen + 4);
    check({tag, " tx_en span"}, last_en - first_en + 1, 8 + plen + 4);
    for (int i = 0; i < cap.size() && i < 8 + plen; i++) begin
      if (i < 7)            e = 8'h55;
      else if (i == 7)      e = 8'hD5;
      else if (i < 8 + len) e = pl[i - 8];
      else                  e = 8'h00;
      if (cap[i] !== e) bad++;
    end
    check({tag, " byte errors"}, bad, 0);
    check({tag, " fcs residue"}, zlib_crc_of_cap(8), 32'h2144_DF1C);
    check({tag, " ack count"}, ack_cnt, 1);
    check({tag, " ack position"}, ack_pos, 6);
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " done after last fcs"}, done_cyc - last_en, 1);
    check({tag, " underrun count"}, un_cnt, 0);
    check({tag, " tx_er count"}, er_cnt, 0);
    check({tag, " tx_en after frame"}, en_after, 0);
    check({tag, " tx_busy at end"}, 32'(busy_end), 32'(exp_busy));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_last;
    int len;
    int bad;
    tests = 0;
    fails = 0;
    cyc   = 0;
    bus.mac_tx_rq    = 1'b0;
    bus.mac_tx_valid = 1'b0;
    bus.mac_tx_data  = 8'h00;
    bus.mac_tx_sof   = 1'b0;
    bus.mac_tx_eof   = 1'b0;
    rst = 1'b1;
    idle(3);
    check("reset gmii_txd", 32'(gmii_txd), 32'd0);
    check("reset gmii_tx_en", 32'(gmii_tx_en), 32'd0);
    check("reset gmii_tx_er", 32'(gmii_tx_er), 32'd0);
    check("reset mac_tx_ack", 32'(bus.mac_tx_ack), 32'd0);
    check("reset tx_busy", 32'(tx_busy), 32'd0);
    check("reset tx_done", 32'(tx_done), 32'd0);
    check("reset tx_underrun", 32'(tx_underrun), 32'd0);
    rst = 1'b0;
    idle(2);

    // 64-byte incrementing payload: 76 tx_en cycles, no pad.
    for (int i = 0; i < 64; i++) pl[i] = 8'(i);
    run_frame(64, -1, -1, 0, 16);
    verify_good("f64", 64, 1'b0);

    // Single byte with sof=eof: 0xAB + 59 zeros, 72 tx_en cycles.
    pl[0] = 8'hAB;
    run_frame(1, -1, -1, 0, 16);
    verify_good("f1", 1, 1'b0);

    // One short of the minimum: exactly one pad byte.
    for (int i = 0; i < 59; i++) pl[i] = 8'(i * 3 + 1);
    run_frame(59, -1, -1, 0, 16);
    verify_good("f59", 59, 1'b0);

    // Exactly the minimum: no pad.
    for (int i = 0; i < 60; i++) pl[i] = 8'(8'hF0 - 8'(i));
    run_frame(60, -1, -1, 0, 16);
    verify_good("f60", 60, 1'b0);

    // Random lengths and contents for the FCS residue.
    for (int r = 0; r < 3; r++) begin
      len = int'($urandom_range(1514, 60));
      for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
      run_frame(len, -1, -1, 0, 16);
      verify_good($sformatf("rnd%0d", r), len, 1'b0);
    end

    // Underrun after 10 bytes: tx_er on the 11th post-SFD cycle, no FCS.
    for (int i = 0; i < 30; i++) pl[i] = 8'(8'h80 + 8'(i));
    run_frame(30, 10, -1, 0, 20);
    check("ur tx_en cycles", en_cnt, 19);
    check("ur tx_er count", er_cnt, 1);
    check("ur tx_er position", er_pos, 18);
    check("ur underrun count", un_cnt, 1);
    check("ur done count", done_cnt, 0);
    check("ur ack position", ack_pos, 6);
    bad = 0;
    for (int i = 8; i < 18 && i < cap.size(); i++) if (cap[i] !== pl[i - 8]) bad++;
    check("ur byte errors", bad, 0);
    check("ur idle after abort", en_after, 0);
    check("ur tx_busy at end", 32'(busy_end), 32'd0);

    // Back-to-back: rq low for one cycle, next preamble after 12 idle cycles.
    for (int i = 0; i < 60; i++) pl[i] = 8'(i ^ 8'h5A);
    run_frame(60, -1, -1, 1, 4);
    verify_good("b2b A", 60, 1'b1);
    a_last = last_en;
    run_frame(60, -1, -1, 0, 16);
    verify_good("b2b B", 60, 1'b0);
    check("b2b idle gap", first_en - a_last - 1, IFG);

    // rq held high after the grant: no second frame.
    run_frame(60, -1, -1, 2, 40);
    verify_good("hold", 60, 1'b0);
    bus.mac_tx_rq = 1'b0;
    idle(3);

    // Reset while payload byte 20 is on the wire.
    for (int i = 0; i < 64; i++) pl[i] = 8'(i);
    run_frame(64, -1, 20, 0, 20);
    check("rst bytes sent", cap.size(), 29);
    check("rst done count", done_cnt, 0);
    check("rst underrun count", un_cnt, 0);
    check("rst tx_en after", en_after, 0);
    check("rst tx_busy at end", 32'(busy_end), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_tx_gmii.md
MAC_TX_GMII -- requirements
Module: mac_tx_gmii

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12, giving idle cycles (tx_en=0) after each frame.
REQ-002 SHALL have parameter MIN_LEN, default 60, giving the minimum bytes (payload+pad) before FCS.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port rst  in  1  reset, synchronous to clk, active-high.
REQ-005 SHALL have port mac_tx_rq  in  1  upstream frame request, held high until the frame is handed over.
REQ-006 SHALL have port mac_tx_ack  out  1  one-cycle grant to upstream.
REQ-007 SHALL have port mac_tx_data  in  8  payload byte.
REQ-008 SHALL have port mac_tx_valid  in  1  mac_tx_data valid.
REQ-009 SHALL have port mac_tx_sof  in  1  first byte marker (informational only).
REQ-010 SHALL have port mac_tx_eof  in  1  last byte marker.
REQ-011 SHALL have port gmii_txd  out  8  GMII transmit data.
REQ-012 SHALL have port gmii_tx_en  out  1  GMII transmit enable.
REQ-013 SHALL have port gmii_tx_er  out  1  GMII transmit error.
REQ-014 SHALL have port tx_busy  out  1  high whenever state is not IDLE.
REQ-015 SHALL have port tx_done  out  1  one-cycle pulse on good frame completion.
REQ-016 SHALL have port tx_underrun  out  1  one-cycle pulse on aborted frame.

Function
REQ-017 SHALL implement the states IDLE, PREAMBLE, DATA, PAD, FCS and IFG; all outputs SHALL be registered.
REQ-018 IDLE -> PREAMBLE SHALL occur when mac_tx_rq=1 and rearm=1; rearm SHALL clear on ack and set on any cycle with mac_tx_rq=0.
REQ-019 PREAMBLE SHALL drive 8 cycles of gmii_tx_en=1: bytes 0-6 = 0x55, byte 7 = 0xD5 (SFD).
REQ-020 mac_tx_ack SHALL be high for exactly one cycle, coincident with preamble byte 6 on gmii_txd.
REQ-021 Upstream's first byte SHALL be valid during the SFD cycle; it SHALL appear on gmii_txd the next cycle, giving 1-cycle input-to-GMII latency with no gap.
REQ-022 DATA SHALL accept one byte per cycle while mac_tx_valid=1, forward it, update the CRC and increment a 16-bit saturating byte count.
REQ-023 When the eof byte is accepted, DATA SHALL go to PAD if count<MIN_LEN, else to FCS.
REQ-024 PAD SHALL drive 0x00 bytes (CRC updated) until count=MIN_LEN, then go to FCS.
REQ-025 CRC SHALL be IEEE 802.3 CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, over payload+pad only, one byte per cycle.
REQ-026 FCS SHALL emit ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24] in 4 consecutive cycles.
REQ-027 tx_done SHALL pulse in the cycle after the last FCS byte, which is also the first IFG cycle.
REQ-028 IFG SHALL hold gmii_tx_en=0 and gmii_txd=0x00 for IFG_CYCLES cycles, then go to IDLE.
REQ-029 Underrun: mac_tx_valid=0 in DATA before eof SHALL drive gmii_tx_en=1, gmii_tx_er=1 for one cycle, pulse tx_underrun, skip PAD/FCS, then go to IFG.
REQ-030 gmii_tx_er SHALL be 0 in all cases other than underrun.
REQ-031 A byte with sof and eof in the same cycle SHALL be a 1-byte payload, padded with MIN_LEN-1 zeros.
REQ-032 Inputs in states other than DATA SHALL be ignored.
REQ-033 mac_tx_rq rising or held during PREAMBLE..IFG SHALL not alter the current frame.

Reset
REQ-034 On rst=1, the next clk edge SHALL set: state=IDLE, rearm=1, CRC=0xFFFFFFFF, count=0, and every output to 0.
REQ-035 Reset mid-frame SHALL drop gmii_tx_en on the next edge, with no FCS and no tx_done or tx_underrun pulse.

Verification
REQ-036 64-byte payload 0x00..0x3F: 7x0x55, 0xD5, 64 bytes, 4 FCS bytes; tx_en high for 76 contiguous cycles, ack single pulse on preamble byte 6, tx_done once.
REQ-037 1-byte payload 0xAB (sof=eof=1): 0xAB, 59x0x00, then FCS; 72 tx_en cycles.
REQ-038 FCS check: zlib crc32 over the emitted payload+pad+FCS SHALL equal 0x2144DF1C for random 60..1514-byte frames.
REQ-039 Underrun: valid drops after 10 bytes -> tx_er=1 for 1 cycle on the 11th post-SFD cycle, tx_underrun pulse, no FCS, then 12 idle cycles.
REQ-040 Back-to-back: rq low 1 cycle between frames -> the next 0x55 appears exactly 12 cycles after the last FCS byte; rq held high without a low cycle -> no second frame.
REQ-041 rst asserted at payload byte 20 -> tx_en=0 and ack=0 the next cycle, tx_busy=0, no tx_done.
